// File: rtl/clmul_seq.sv
// Sequential carry-less multiplier (Zbc clmul/clmulh/clmulr), STEP multiplier bits per cycle.
// The high and reversed variants reuse the low-half datapath by bit-reversing the operands and the product.
module clmul_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Start,
  input  logic [1:0]       Funct,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int            NSTEPS = WIDTH / STEP;
  localparam int            CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CW-1:0] LAST   = CW'(NSTEPS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       funct_q, funct_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_acc;
  logic             rev_ops;

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  assign rev_ops = (Funct == 2'b01) || (Funct == 2'b10);

  // Accumulator value after consuming the next STEP multiplier bits.
  always_comb begin
    step_acc = acc_q;
    for (int j = 0; j < STEP; j++) begin
      if (mplr_q[j]) step_acc = step_acc ^ (mcand_q << j);
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    funct_d  = funct_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          state_d = RUN;
          mcand_d = rev_ops ? bit_rev(A) : A;
          mplr_d  = rev_ops ? bit_rev(B) : B;
          funct_d = Funct;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d   = step_acc;
        mcand_d = mcand_q << STEP;
        mplr_d  = mplr_q >> STEP;
        cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          case (funct_q)
            2'b01:   result_d = bit_rev(step_acc) >> 1;
            2'b10:   result_d = bit_rev(step_acc);
            default: result_d = step_acc;
          endcase
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // An abort must leave the previously delivered Result untouched.
    if (Flush) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      funct_q  <= 2'b00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      funct_q  <= funct_d;
      done_q   <= done_d;
    end
  end

  assign Busy   = (state_q != IDLE);
  assign Done   = done_q;
  assign Result = result_q;

endmodule
